// File: rtl/sgb_packet_tx_if.sv
// rtl/sgb_packet_tx_if.sv - buffer write port, control and joypad-line bundle for sgb_packet_tx
// Signals, named from the transmitter's point of view:
//   i_ce       GB clock enable; protocol timers advance only when high
//   i_wr       buffer write strobe
//   i_addr     buffer byte index 0..15
//   i_wdata    buffer write data
//   i_start    begin transmission (level)
//   i_abort    cancel transmission
//   o_joy_p54  [0]=P14, [1]=P15, low = asserted, idle 2'b11
//   o_busy     packet in progress
//   o_done     one-clk pulse at end of the post-packet gap
//   o_pending  next packet queued (double-buffer build only)
// Modports: master drives the controls, slave is the transmitter.
interface sgb_packet_tx_if;
  logic       i_ce;
  logic       i_wr;
  logic [3:0] i_addr;
  logic [7:0] i_wdata;
  logic       i_start;
  logic       i_abort;
  logic [1:0] o_joy_p54;
  logic       o_busy;
  logic       o_done;
  logic       o_pending;

  modport master (
    output i_ce, i_wr, i_addr, i_wdata, i_start, i_abort,
    input  o_joy_p54, o_busy, o_done, o_pending
  );

  modport slave (
    input  i_ce, i_wr, i_addr, i_wdata, i_start, i_abort,
    output o_joy_p54, o_busy, o_done, o_pending
  );
endinterface

// File: rtl/sgb_packet_tx.sv
// rtl/sgb_packet_tx.sv - Game Boy-side SGB 16-byte command packet transmitter on P14/P15
// Sends a reset pulse (both lines low), 128 data bits LSB-first from byte 0, then a 0 stop bit,
// followed by an idle gap. Each bit is a low phase on P14 (0) or P15 (1) and a high phase.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous, active-high reset
//   bus      sgb_packet_tx_if.slave (ce, write port, start/abort, joy_p54, busy/done/pending)
// Optional feature: define SGB_TX_DBUF_EN for a shadow buffer and back-to-back queued packets.
module sgb_packet_tx #(
  parameter int HOLD_CE = 2,
  parameter int RST_CE  = 4,
  parameter int GAP_CE  = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  sgb_packet_tx_if.slave bus
);
  localparam int            TW      = 16;
  localparam logic [TW-1:0] HOLD_M1 = TW'(HOLD_CE - 1);
  localparam logic [TW-1:0] RST_M1  = TW'(RST_CE - 1);
  localparam logic [TW-1:0] GAP_M1  = TW'(GAP_CE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_LO, S_RST_HI, S_BIT_LO, S_BIT_HI, S_STOP_LO, S_STOP_HI, S_GAP
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick;
  logic [6:0]    r_bit_cnt;
  logic [7:0]    r_byte;
  logic [1:0]    r_joy;
  logic          r_busy;
  logic          r_done;

  logic [TW-1:0] w_len_m1;
  logic          w_tick_end;
  logic          w_finish;
  logic [6:0]    w_cnt_in;
  logic [7:0]    w_fetch;
  logic          w_bit;

`ifdef SGB_TX_DBUF_EN
  logic [7:0] r_buf [2][16];
  logic       r_act;
  logic       r_pending;
  logic       w_wr_sel;

  // While a packet is on the wire, writes land in the shadow buffer.
  assign w_wr_sel = r_busy ? ~r_act : r_act;

  always_ff @(posedge i_clk) begin
    if (bus.i_wr) r_buf[w_wr_sel][bus.i_addr] <= bus.i_wdata;
  end

  assign w_fetch       = r_buf[r_act][w_cnt_in[6:3]];
  assign bus.o_pending = r_pending;
`else
  logic [7:0] r_buf [16];

  always_ff @(posedge i_clk) begin
    if (bus.i_wr && !r_busy) r_buf[bus.i_addr] <= bus.i_wdata;
  end

  assign w_fetch       = r_buf[w_cnt_in[6:3]];
  assign bus.o_pending = 1'b0;
`endif

  always_comb begin
    w_len_m1 = HOLD_M1;
    case (r_state)
      S_RST_LO: w_len_m1 = RST_M1;
      S_GAP:    w_len_m1 = GAP_M1;
      default:  ;
    endcase
  end

  assign w_tick_end = bus.i_ce && (r_tick == w_len_m1);
  // With no gap configured the packet ends straight out of the stop-bit high phase.
  assign w_finish   = (r_state == S_GAP) || ((r_state == S_STOP_HI) && (GAP_CE == 0));
  // Bit index that the next BIT_LO will present (counter advances on leaving BIT_HI).
  assign w_cnt_in   = (r_state == S_BIT_HI) ? r_bit_cnt + 7'd1 : r_bit_cnt;
  // Bit 0 of a byte comes straight from the buffer, the rest from the latched byte.
  assign w_bit      = (w_cnt_in[2:0] == 3'd0) ? w_fetch[0] : r_byte[w_cnt_in[2:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_byte    <= '0;
      r_joy     <= 2'b11;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SGB_TX_DBUF_EN
      r_act     <= 1'b0;
      r_pending <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.i_abort) begin
        r_state <= S_IDLE;
        r_tick  <= '0;
        r_joy   <= 2'b11;
        r_busy  <= 1'b0;
`ifdef SGB_TX_DBUF_EN
        r_pending <= 1'b0;
`endif
      end else if (r_state == S_IDLE) begin
        // Start is taken only on a ce edge so the line change lands on a GB tick.
        if (bus.i_ce && bus.i_start) begin
          r_state   <= S_RST_LO;
          r_tick    <= '0;
          r_bit_cnt <= '0;
          r_joy     <= 2'b00;
          r_busy    <= 1'b1;
        end
      end else begin
`ifdef SGB_TX_DBUF_EN
        if (bus.i_start) r_pending <= 1'b1;
`endif
        if (bus.i_ce && !w_tick_end) begin
          r_tick <= r_tick + TW'(1);
        end else if (w_tick_end) begin
          r_tick <= '0;
          if (w_finish) begin
            r_done <= 1'b1;
`ifdef SGB_TX_DBUF_EN
            if (r_pending) begin
              r_pending <= 1'b0;
              r_act     <= ~r_act;
              r_state   <= S_RST_LO;
              r_bit_cnt <= '0;
              r_joy     <= 2'b00;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            case (r_state)
              S_RST_LO: begin
                r_state <= S_RST_HI;
                r_joy   <= 2'b11;
              end
              S_RST_HI, S_BIT_HI: begin
                r_bit_cnt <= w_cnt_in;
                if ((r_state == S_BIT_HI) && (r_bit_cnt == 7'd127)) begin
                  r_state <= S_STOP_LO;
                  r_joy   <= 2'b10;
                end else begin
                  r_state <= S_BIT_LO;
                  r_joy   <= w_bit ? 2'b01 : 2'b10;
                  if (w_cnt_in[2:0] == 3'd0) r_byte <= w_fetch;
                end
              end
              S_BIT_LO: begin
                r_state <= S_BIT_HI;
                r_joy   <= 2'b11;
              end
              S_STOP_LO: begin
                r_state <= S_STOP_HI;
                r_joy   <= 2'b11;
              end
              S_STOP_HI: begin
                r_state <= S_GAP;
                r_joy   <= 2'b11;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign bus.o_joy_p54 = r_joy;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
endmodule
